// File: rtl/hamming_pkg.sv
// hamming_pkg: Hamming(7,4) widths and the shared encode function.
package hamming_pkg;
  localparam int DATA_W = 4;
  localparam int CODE_W = 7;
  function automatic logic [CODE_W-1:0] hamming74_enc(input logic [DATA_W-1:0] d);
    return {d, d[3] ^ d[2] ^ d[1], d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0]};
  endfunction
endpackage

// File: rtl/hamming_fifo2.sv
// hamming_fifo2: 2-entry valid/ready FIFO; in_ready depends on registered occupancy only.
module hamming_fifo2 #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic         push, pop;
  assign in_ready  = cnt_q != 2'd2;
  assign out_valid = cnt_q != 2'd0;
  assign out_data  = head_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // push implies count<2 and push&pop implies count==1, so either case writes the head
  always_comb begin
    cnt_d  = cnt_q + 2'(push) - 2'(pop);
    head_d = (push && (cnt_q == 2'd0 || pop)) ? in_data : (pop ? tail_q : head_q);
    tail_d = (push && cnt_q == 2'd1 && !pop) ? in_data : tail_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
endmodule

// File: rtl/hamming74_stream_encoder.sv
// hamming74_stream_encoder: streaming Hamming(7,4) encoder with 2-deep output FIFO and beat counter.
// Optional one-shot codeword corruption enabled by macro HAMMING_ERR_INJECT_EN.
module hamming74_stream_encoder
  import hamming_pkg::*;
#(
  parameter int LANES = 1,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W*LANES-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CODE_W*LANES-1:0]   out_code,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          beat_cnt,
  output logic                      cnt_sat,
  input  logic                      inj_arm,
  input  logic [CODE_W*LANES-1:0]   inj_mask,
  output logic                      inj_pending
);
  logic [CODE_W*LANES-1:0] clean_code, code_w, mask_eff;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sat_q, accept;
  assign accept = in_valid & in_ready;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign clean_code[g*CODE_W +: CODE_W] = hamming74_enc(in_data[g*DATA_W +: DATA_W]);
  end
`ifdef HAMMING_ERR_INJECT_EN
  logic                    inj_pending_q, inj_pending_d;
  logic [CODE_W*LANES-1:0] inj_mask_q, inj_mask_d;
  // an arm coinciding with an accept applies its mask to that accept directly
  always_comb begin
    mask_eff      = inj_arm ? inj_mask : (inj_pending_q ? inj_mask_q : '0);
    inj_pending_d = accept ? 1'b0 : (inj_arm | inj_pending_q);
    inj_mask_d    = inj_arm ? inj_mask : inj_mask_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_pending_q <= 1'b0;
      inj_mask_q    <= '0;
    end else begin
      inj_pending_q <= inj_pending_d;
      inj_mask_q    <= inj_mask_d;
    end
  end
  assign inj_pending = inj_pending_q;
`else
  logic unused_inj;
  assign unused_inj  = ^{inj_arm, inj_mask};
  assign mask_eff    = '0;
  assign inj_pending = 1'b0;
`endif
  assign code_w = clean_code ^ mask_eff;
  always_comb cnt_d = cnt_clr ? '0 : ((accept && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= &cnt_d;
    end
  end
  assign beat_cnt = cnt_q;
  assign cnt_sat  = sat_q;
  hamming_fifo2 #(.W(CODE_W*LANES)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (code_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_code)
  );
endmodule
